// File: rtl/if_stage_if.sv
// Bus bundle for the instruction-fetch stage: hazard controls, ID feedback, imem port and IF/ID.
// master is the fetch stage side; slave is the surrounding pipeline and memory.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_source;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  modport master (
    input  stall,
    input  flush,
    input  pc_source,
    input  branch_taken,
    input  branch_target,
    input  jr_target,
    input  imem_rdata,
    output imem_addr,
    output pc,
    output ifid_instr,
    output ifid_pc_plus4,
    output ifid_valid
  );

  modport slave (
    output stall,
    output flush,
    output pc_source,
    output branch_taken,
    output branch_target,
    output jr_target,
    output imem_rdata,
    input  imem_addr,
    input  pc,
    input  ifid_instr,
    input  ifid_pc_plus4,
    input  ifid_valid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with PC register, next-PC selection and IF/ID pipeline register.
// Optional macro IF_DELAY_SLOT_EN keeps the fetched word on a redirect (MIPS branch delay slot).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.master bus
);

  localparam logic [1:0] PcSrcJr   = 2'b01;
  localparam logic [1:0] PcSrcJump = 2'b10;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] raw_target;
  logic [31:0] redirect_target;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect only for a real instruction in ID; a bubble carries a stale pc_source.
  always_comb begin
    redirect   = 1'b0;
    raw_target = pc_plus4;
    if (ifid_valid_q) begin
      if (bus.branch_taken) begin
        redirect   = 1'b1;
        raw_target = bus.branch_target;
      end else if (bus.pc_source == PcSrcJr) begin
        redirect   = 1'b1;
        raw_target = bus.jr_target;
      end else if (bus.pc_source == PcSrcJump) begin
        redirect   = 1'b1;
        raw_target = {ifid_pc_plus4_q[31:28], ifid_instr_q[25:0], 2'b00};
      end
    end
    redirect_target = {raw_target[31:2], 2'b00};
  end

  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;

    if (bus.stall) begin
      // ID re-presents next cycle, so any redirect is deferred rather than lost.
      if (bus.flush) begin
        ifid_instr_d    = 32'h0;
        ifid_pc_plus4_d = 32'h0;
        ifid_valid_d    = 1'b0;
      end
    end else if (redirect) begin
      pc_d = redirect_target;
`ifdef IF_DELAY_SLOT_EN
      if (bus.flush) begin
        ifid_instr_d    = 32'h0;
        ifid_pc_plus4_d = 32'h0;
        ifid_valid_d    = 1'b0;
      end else begin
        ifid_instr_d    = bus.imem_rdata;
        ifid_pc_plus4_d = pc_plus4;
        ifid_valid_d    = 1'b1;
      end
`else
      ifid_instr_d    = 32'h0;
      ifid_pc_plus4_d = 32'h0;
      ifid_valid_d    = 1'b0;
`endif
    end else begin
      pc_d = pc_plus4;
      if (bus.flush) begin
        ifid_instr_d    = 32'h0;
        ifid_pc_plus4_d = 32'h0;
        ifid_valid_d    = 1'b0;
      end else begin
        ifid_instr_d    = bus.imem_rdata;
        ifid_pc_plus4_d = pc_plus4;
        ifid_valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= 32'h0;
      ifid_pc_plus4_q <= 32'h0;
      ifid_valid_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.imem_addr     = pc_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
  assign bus.ifid_valid    = ifid_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (reset PC 0 and FFFF_FFF8) on shared stimulus, checked
// every cycle against a behavioural model, plus directed checks with fixed expected values.
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [1:0]  pc_source = 2'b00;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] jr_target = 32'h0;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0800_0010;  // j 0x40
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  if_stage_if ifc0 ();
  if_stage_if ifc1 ();

  assign ifc0.stall = stall;
  assign ifc0.flush = flush;
  assign ifc0.pc_source = pc_source;
  assign ifc0.branch_taken = branch_taken;
  assign ifc0.branch_target = branch_target;
  assign ifc0.jr_target = jr_target;
  assign ifc0.imem_rdata = mem_word(ifc0.imem_addr);
  assign ifc1.stall = stall;
  assign ifc1.flush = flush;
  assign ifc1.pc_source = pc_source;
  assign ifc1.branch_taken = branch_taken;
  assign ifc1.branch_target = branch_target;
  assign ifc1.jr_target = jr_target;
  assign ifc1.imem_rdata = mem_word(ifc1.imem_addr);

  if_stage dut0 (.clk(clk), .rst(rst), .bus(ifc0.master));
  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.master));

  logic [31:0] obs_pc [2];
  logic [31:0] obs_addr [2];
  logic [31:0] obs_instr [2];
  logic [31:0] obs_pp4 [2];
  logic        obs_valid [2];
  assign obs_pc[0] = ifc0.pc;
  assign obs_pc[1] = ifc1.pc;
  assign obs_addr[0] = ifc0.imem_addr;
  assign obs_addr[1] = ifc1.imem_addr;
  assign obs_instr[0] = ifc0.ifid_instr;
  assign obs_instr[1] = ifc1.ifid_instr;
  assign obs_pp4[0] = ifc0.ifid_pc_plus4;
  assign obs_pp4[1] = ifc1.ifid_pc_plus4;
  assign obs_valid[0] = ifc0.ifid_valid;
  assign obs_valid[1] = ifc1.ifid_valid;

  // Model state per instance.
  logic [31:0] m_pc [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_pp4 [2];
  logic        m_valid [2];

  function automatic logic [31:0] reset_pc(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply current inputs for one clock edge, advance the model, and compare both instances.
  task automatic step();
    logic [31:0] npc [2];
    logic [31:0] ni [2];
    logic [31:0] np [2];
    logic        nv [2];
    for (int d = 0; d < 2; d++) begin
      logic [31:0] tgt;
      logic [31:0] seq;
      logic        redir;
      seq   = m_pc[d] + 32'd4;
      redir = 1'b0;
      tgt   = 32'h0;
      if (m_valid[d]) begin
        if (branch_taken) begin
          redir = 1'b1; tgt = branch_target;
        end else if (pc_source == 2'b01) begin
          redir = 1'b1; tgt = jr_target;
        end else if (pc_source == 2'b10) begin
          redir = 1'b1;
          tgt = (m_pp4[d] & 32'hF000_0000) | ((m_instr[d] & 32'h03FF_FFFF) * 4);
        end
      end
      tgt = tgt - (tgt % 4);
      npc[d] = m_pc[d]; ni[d] = m_instr[d]; np[d] = m_pp4[d]; nv[d] = m_valid[d];
      if (rst) begin
        npc[d] = reset_pc(d); ni[d] = 0; np[d] = 0; nv[d] = 0;
      end else if (stall) begin
        if (flush) begin ni[d] = 0; np[d] = 0; nv[d] = 0; end
      end else begin
        npc[d] = redir ? tgt : seq;
`ifdef IF_DELAY_SLOT_EN
        redir = 1'b0;
`endif
        if (flush || redir) begin
          ni[d] = 0; np[d] = 0; nv[d] = 0;
        end else begin
          ni[d] = mem_word(m_pc[d]); np[d] = seq; nv[d] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = npc[d]; m_instr[d] = ni[d]; m_pp4[d] = np[d]; m_valid[d] = nv[d];
      check($sformatf("d%0d pc", d), obs_pc[d], m_pc[d]);
      check($sformatf("d%0d imem_addr", d), obs_addr[d], m_pc[d]);
      check($sformatf("d%0d ifid_instr", d), obs_instr[d], m_instr[d]);
      check($sformatf("d%0d ifid_pc_plus4", d), obs_pp4[d], m_pp4[d]);
      check($sformatf("d%0d ifid_valid", d), {31'h0, obs_valid[d]}, {31'h0, m_valid[d]});
    end
  endtask

  initial begin
    logic [31:0] jt;
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 0; m_instr[d] = 0; m_pp4[d] = 0; m_valid[d] = 0;
    end

    // Reset and free run.
    rst = 1'b1;
    step();
    check("rst pc0", ifc0.pc, 32'h0);
    check("rst pc1", ifc1.pc, 32'hFFFF_FFF8);
    check("rst valid0", {31'h0, ifc0.ifid_valid}, 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("run pc0", ifc0.pc, 32'(4 * i));
      check("run pp4", ifc0.ifid_pc_plus4, 32'(4 * i));
      check("run valid", {31'h0, ifc0.ifid_valid}, 32'h1);
      if (i == 1) check("wrap pc1 a", ifc1.pc, 32'hFFFF_FFFC);
      if (i == 2) check("wrap pc1 b", ifc1.pc, 32'h0);
    end

    // Jump: j 0x40 sits in IF/ID while pc=8.
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    check("j in ifid", ifc0.ifid_instr, 32'h0800_0010);
    check("j fetch pc", ifc0.pc, 32'h8);
    pc_source = 2'b10;
    step();
    check("j pc", ifc0.pc, 32'h40);
`ifndef IF_DELAY_SLOT_EN
    check("j bubble", {31'h0, ifc0.ifid_valid}, 32'h0);
`endif
    pc_source = 2'b00;
    step();
    check("j target instr", ifc0.ifid_instr, mem_word(32'h40));
    check("j after pc", ifc0.pc, 32'h44);

    // Branch beats jr; then jr alone with unaligned target.
    branch_taken = 1'b1; branch_target = 32'h100; pc_source = 2'b01; jr_target = 32'h200;
    step();
    check("branch wins", ifc0.pc, 32'h100);
    branch_taken = 1'b0; pc_source = 2'b00;
    step();
    pc_source = 2'b01; jr_target = 32'h203;
    step();
    check("jr aligned", ifc0.pc, 32'h200);
    pc_source = 2'b00;
    step();

    // Stall with a pending jump: frozen, then redirect exactly once.
    jt = (32'h204 & 32'hF000_0000) | ((mem_word(32'h200) & 32'h03FF_FFFF) << 2);
    stall = 1'b1; pc_source = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall pc", ifc0.pc, 32'h204);
      check("stall instr", ifc0.ifid_instr, mem_word(32'h200));
    end
    stall = 1'b0;
    step();
    check("stall release jump", ifc0.pc, jt);
    pc_source = 2'b00;
    step();
    check("jump once", ifc0.pc, jt + 32'd4);

    // Single-cycle flush.
    flush = 1'b1;
    step();
    check("flush valid", {31'h0, ifc0.ifid_valid}, 32'h0);
    check("flush pc", ifc0.pc, jt + 32'd8);
    flush = 1'b0;
    step();
    check("post flush valid", {31'h0, ifc0.ifid_valid}, 32'h1);

    // Reset while a jr is pending.
    pc_source = 2'b01; jr_target = 32'h500; rst = 1'b1;
    step();
    check("midrst pc", ifc0.pc, 32'h0);
    check("midrst valid", {31'h0, ifc0.ifid_valid}, 32'h0);
    rst = 1'b0; pc_source = 2'b00;
    step();
    check("midrst no jump", ifc0.pc, 32'h4);

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      pc_source     = 2'($urandom_range(0, 3));
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_target = $urandom;
      jr_target     = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage with integrated IF/ID pipeline register, directly upstream of the decode controller.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from sequential, jump, jump-register and taken-branch sources, using the controller's PC_source decode fed back from ID.
- Latches the fetched instruction into IF/ID with valid, stall and flush control.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  hazard unit: load a bubble into IF/ID.
- pc_source  input  2  controller decode of the ID instruction: 00 sequential, 01 jr, 10 j/jal, 11 treated as 00.
- branch_taken  input  1  resolved conditional branch in ID is taken.
- branch_target  input  32  branch destination computed in ID.
- jr_target  input  32  rs value (forwarded) for jr.
- imem_addr  output  32  instruction memory address; equals pc combinationally.
- imem_rdata  input  32  instruction word; combinational read, valid in the same cycle.
- pc  output  32  current fetch PC.
- ifid_instr  output  32  IF/ID instruction; drives controller opcode [31:26] and func [5:0].
- ifid_pc_plus4  output  32  IF/ID copy of fetch PC + 4.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst=1 at edge, overrides all inputs):
  - pc=RESET_PC
  - ifid_instr=32'h0 (sll $0,$0,0 NOP)
  - ifid_pc_plus4=32'h0
  - ifid_valid=0
  - Reset mid-stream discards any pending redirect.
- Redirect is qualified by ifid_valid; a bubble in ID never redirects.
- Redirect target priority:
  - branch_taken → branch_target
  - pc_source=01 → jr_target
  - pc_source=10 → {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}
  - otherwise no redirect.
- All targets are word-aligned by forcing bits [1:0] to 0.
- Sequential next PC is pc + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0.
- Per-edge update priority (rst excluded):
  1. stall=1: pc holds and any redirect is ignored, because the ID instruction re-presents next cycle. IF/ID holds unless flush=1, in which case IF/ID becomes a bubble.
  2. stall=0, redirect: pc ← target. IF/ID loads a bubble (the fetched wrong-path word is discarded; see Optional Feature).
  3. stall=0, no redirect: pc ← pc+4. IF/ID ← {imem_rdata, pc+4, valid=1}, unless flush=1, in which case it loads a bubble.
- Bubble means ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0.
- Fetch latency: an instruction at address A appears on ifid_instr one edge after pc=A with stall=0.
- Redirect penalty is one cycle: the target instruction is in IF/ID two edges after the redirecting instruction enters IF/ID.
- imem_addr always equals pc, including during stall and reset.

Optional Feature:
- Macro: IF_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot. On a redirect with stall=0, IF/ID loads the fetched word {imem_rdata, pc+4, valid=1} instead of a bubble, unless flush=1. Redirect penalty becomes zero.
- Undefined: behaviour exactly as above; the wrong-path word is squashed.

Test Plan:
- Reset then 4 free-run cycles with imem_rdata=addr-derived pattern → pc 0,4,8,12,16; ifid_pc_plus4 4,8,12,16; ifid_valid 0 then 1.
- j 0x0000_0040 (ifid_instr=32'h0800_0010, pc_source=10) at fetch pc=8 → next pc=0x40; IF/ID bubble; without IF_DELAY_SLOT_EN, instruction at 0x40 follows directly.
- branch_taken=1, branch_target=0x100, simultaneously pc_source=01, jr_target=0x200 → pc=0x100 (branch wins); jr_target=0x203 alone → pc=0x200.
- stall=1 for 3 cycles with pc_source=10 asserted → pc and IF/ID frozen, no redirect; after release redirect taken exactly once.
- RESET_PC=32'hFFFF_FFF8, no stalls → pc FFFF_FFF8, FFFF_FFFC, 0000_0000; flush=1 on one cycle → ifid_valid=0 for that cycle only while pc still advances.
- rst asserted mid-redirect (pc_source=01 pending) → pc=RESET_PC, ifid_valid=0, no jump taken.
